// File: rtl/sc_seq_fsm_if.sv
// rtl/sc_seq_fsm_if.sv - control and framing signals of the sequence controller
interface sc_seq_fsm_if #(
  parameter int W   = 7,
  parameter int P_W = 3
);
  logic           start;
  logic [W-1:0]   len;
  logic [P_W-1:0] passes;
  logic           stall;
  logic           abort;
  logic [W-1:0]   idx;
  logic [P_W-1:0] pass_idx;
  logic           valid;
  logic           sop;
  logic           eop;
  logic           busy;
  logic           done;

  modport master (
    output start, len, passes, stall, abort,
    input  idx, pass_idx, valid, sop, eop, busy, done
  );

  modport slave (
    input  start, len, passes, stall, abort,
    output idx, pass_idx, valid, sop, eop, busy, done
  );
endinterface

// File: rtl/sc_seq_fsm.sv
// rtl/sc_seq_fsm.sv - stochastic-computing sequence controller (index/pass counter with framing)
module sc_seq_fsm #(
  parameter int W    = 7,
  parameter int P_W  = 3,
  parameter int MODE = 0
) (
  input  logic        clk,
  input  logic        rst,
  sc_seq_fsm_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [W:0]     L_ONE   = {{W{1'b0}}, 1'b1};
  localparam logic [W:0]     L_MAX   = {1'b1, {W{1'b0}}};
  localparam logic [P_W:0]   N_ONE   = {{P_W{1'b0}}, 1'b1};
  localparam logic [P_W:0]   N_MAX   = {1'b1, {P_W{1'b0}}};
  localparam logic [P_W-1:0] P_ONE   = {{(P_W-1){1'b0}}, 1'b1};

  state_t         r_state, w_state_nx;
  logic [W:0]     r_cnt, w_cnt_nx;
  logic [W:0]     r_len, w_len_nx;
  logic [P_W-1:0] r_pass, w_pass_nx;
  logic [P_W:0]   r_npass, w_npass_nx;
  logic           w_last_cnt;
  logic           w_last_pass;
  logic           w_adv;
  logic [W-1:0]   w_idx;

  assign w_last_cnt  = (r_cnt == (r_len - L_ONE));
  assign w_last_pass = ({1'b0, r_pass} == (r_npass - N_ONE));
  assign w_adv       = (r_state == S_RUN) && !bus.stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pass  <= '0;
      r_len   <= '0;
      r_npass <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_pass  <= w_pass_nx;
      r_len   <= w_len_nx;
      r_npass <= w_npass_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_pass_nx  = r_pass;
    w_len_nx   = r_len;
    w_npass_nx = r_npass;
    case (r_state)
      S_IDLE: begin
        w_cnt_nx  = '0;
        w_pass_nx = '0;
        if (bus.start && !bus.abort) begin
          w_len_nx   = (bus.len == '0)    ? L_MAX : {1'b0, bus.len};
          w_npass_nx = (bus.passes == '0) ? N_MAX : {1'b0, bus.passes};
          w_state_nx = S_RUN;
        end
      end
      S_RUN: begin
        if (!bus.stall) begin
          if (!w_last_cnt) begin
            w_cnt_nx = r_cnt + L_ONE;
          end else if (!w_last_pass) begin
            w_cnt_nx  = '0;
            w_pass_nx = r_pass + P_ONE;
          end else begin
            // counters return to zero so idx/pass_idx read 0 in DONE and IDLE
            w_cnt_nx   = '0;
            w_pass_nx  = '0;
            w_state_nx = S_DONE;
          end
        end
      end
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
    if (bus.abort) begin
      w_state_nx = S_IDLE;
      w_cnt_nx   = '0;
      w_pass_nx  = '0;
    end
  end

  // bit-reversed order gives a low-discrepancy index sequence for the SNGs
  generate
    if (MODE == 1) begin : g_rev
      for (genvar i = 0; i < W; i++) begin : g_bit
        assign w_idx[i] = r_cnt[W-1-i];
      end
    end else begin : g_bin
      assign w_idx = r_cnt[W-1:0];
    end
  endgenerate

  assign bus.idx      = w_idx;
  assign bus.pass_idx = r_pass;
  assign bus.valid    = w_adv;
  assign bus.sop      = w_adv && (r_cnt == '0);
  assign bus.eop      = w_adv && w_last_cnt;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.done     = (r_state == S_DONE);
endmodule

// File: tb/tb_sc_seq_fsm.sv
// tb/tb_sc_seq_fsm.sv - directed bench for sc_seq_fsm (binary and bit-reversed instances)
module tb_sc_seq_fsm;
  localparam int W   = 4;
  localparam int P_W = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           stall;
  logic           abort;
  logic [W-1:0]   len;
  logic [P_W-1:0] passes;
  int             checks   = 0;
  int             failures = 0;

  sc_seq_fsm_if #(.W(W), .P_W(P_W)) b0 ();
  sc_seq_fsm_if #(.W(W), .P_W(P_W)) b1 ();

  assign b0.start  = start;
  assign b0.len    = len;
  assign b0.passes = passes;
  assign b0.stall  = stall;
  assign b0.abort  = abort;
  assign b1.start  = start;
  assign b1.len    = len;
  assign b1.passes = passes;
  assign b1.stall  = stall;
  assign b1.abort  = abort;

  sc_seq_fsm #(.W(W), .P_W(P_W), .MODE(0)) u0 (.clk(clk), .rst(rst), .bus(b0));
  sc_seq_fsm #(.W(W), .P_W(P_W), .MODE(1)) u1 (.clk(clk), .rst(rst), .bus(b1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] rev4(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, b0.busy, 0);
    chk({tag, "_valid"}, b0.valid, 0);
    chk({tag, "_done"}, b0.done, 0);
    chk({tag, "_idx"}, b0.idx, 0);
    chk({tag, "_sop"}, b0.sop, 0);
    chk({tag, "_eop"}, b0.eop, 0);
    chk({tag, "_pass"}, b0.pass_idx, 0);
  endtask

  // noise=1 keeps start high and scrambles len/passes for the whole run
  task automatic run(input int L, input int N, input int st_at, input int st_n, input bit noise);
    int         lq;
    int         nq;
    int         cyc;
    logic [3:0] c4;
    lq = (L == 0) ? 16 : L;
    nq = (N == 0) ? 4 : N;
    start  = 1'b1;
    len    = L[W-1:0];
    passes = N[P_W-1:0];
    #1;
    chk("pre_busy", b0.busy, 0);
    chk("pre_valid", b0.valid, 0);
    tick();
    cyc = 1;
    if (noise) begin
      len    = 4'd1;
      passes = 2'd1;
    end else begin
      start = 1'b0;
    end
    for (int p = 0; p < nq; p++) begin
      for (int c = 0; c < lq; c++) begin
        c4 = c[3:0];
        if (p == 0 && c == st_at) begin
          for (int s = 0; s < st_n; s++) begin
            stall = 1'b1;
            #1;
            chk("stall_valid", b0.valid, 0);
            chk("stall_idx", b0.idx, c4);
            chk("stall_sop", b0.sop, 0);
            chk("stall_eop", b0.eop, 0);
            chk("stall_busy", b0.busy, 1);
            tick();
            cyc++;
          end
        end
        stall = 1'b0;
        #1;
        chk("valid", b0.valid, 1);
        chk("idx", b0.idx, c4);
        chk("idx_rev", b1.idx, rev4(c4));
        chk("sop", b0.sop, (c == 0));
        chk("eop", b0.eop, (c == lq - 1));
        chk("pass_idx", b0.pass_idx, p);
        chk("busy", b0.busy, 1);
        chk("done_early", b0.done, 0);
        tick();
        cyc++;
      end
    end
    #1;
    chk("done", b0.done, 1);
    chk("done_rev", b1.done, 1);
    chk("done_busy", b0.busy, 1);
    chk("done_valid", b0.valid, 0);
    chk("latency", cyc, 1 + lq * nq + st_n);
    tick();
    start  = 1'b0;
    len    = '0;
    passes = '0;
    #1;
    chk_idle_outputs("post");
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    stall  = 1'b0;
    abort  = 1'b0;
    len    = '0;
    passes = '0;
    #12;
    chk_idle_outputs("reset");
    tick();
    rst = 1'b0;
    #1;

    run(5, 1, -1, 0, 1'b0);
    run(0, 1, -1, 0, 1'b0);
    run(6, 1, 2, 3, 1'b0);
    run(3, 3, -1, 0, 1'b0);
    run(1, 2, -1, 0, 1'b1);

    start  = 1'b1;
    len    = 4'd6;
    passes = 2'd1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #1;
    chk("ab_idx_before", b0.idx, 2);
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    #1;
    chk_idle_outputs("ab");
    tick();
    #1;
    chk("ab_done2", b0.done, 0);
    chk("ab_busy2", b0.busy, 0);
    run(2, 1, -1, 0, 1'b0);

    start  = 1'b1;
    len    = 4'd5;
    passes = 2'd2;
    tick();
    start = 1'b0;
    tick();
    tick();
    #1;
    chk("rs_idx_before", b0.idx, 2);
    #2;
    rst = 1'b1;
    #1;
    chk_idle_outputs("rs");
    tick();
    rst = 1'b0;
    #1;
    chk("rs_busy_after", b0.busy, 0);
    run(5, 1, -1, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
